alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Sequential, parametrised successor to the lab combinational ALU.
  - Width is set by a parameter.
  - Inputs and outputs use a valid/ready handshake.
  - Result flags are registered.
  - Adds an optional iterative multiply op.
- Sits between the operand-fetch logic and writeback in the multi-cycle datapath.
- Exactly one operation is in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.
- SHW, $clog2(WIDTH), derived; counter width for the multiply FSM.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operand/op presented
- in_ready  output  1  block can accept an operation this cycle
- X  input  WIDTH  operand A
- Y  input  WIDTH  operand B
- op_code  input  4  operation, `ALU_OP_* encoding
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer takes the result this cycle
- Z  output  WIDTH  result
- equal  output  1  X == Y for the accepted operands
- overflow  output  1  see arithmetic rules
- zero  output  1  Z == 0

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - rst high at a clock edge: state=IDLE, out_valid=0, Z=0, equal=0, overflow=0, zero=0.
  - in_ready is combinationally 1 in IDLE.
  - rst overrides every other input, including mid-multiply: the operation is aborted and its result is never presented.
- Accept: occurs when in_valid && in_ready at the edge.
  - X, Y and op_code are captured.
  - Inputs are ignored when no accept occurs.
- States:
  - IDLE:
    - Accept of a single-cycle op: write Z/flags, go to DONE.
    - Accept of MUL: go to MUL.
  - MUL:
    - Shift-add runs for WIDTH cycles, counter 0..WIDTH-1.
    - After the last cycle, write Z/flags and go to DONE.
    - in_ready=0 throughout.
  - DONE:
    - out_valid=1; Z and flags are held stable until out_ready.
    - out_ready=1: in_ready=1 in the same cycle, so a new accept may occur.
      - If a new accept occurs, next state follows the IDLE rules.
      - If no accept occurs, go to IDLE.
    - out_ready=0: in_ready=0.
- Latency:
  - Single-cycle ops: out_valid rises on the edge of the accept; visible the cycle after accept.
  - MUL: out_valid is visible WIDTH+1 cycles after accept.
  - Back-to-back throughput for single-cycle ops: 1 op/cycle when out_ready=1.
- Ops:
  - AND, OR, XOR, NOR: bitwise.
  - ADD, SUB: modulo 2^WIDTH.
    - overflow = signed two's-complement overflow.
    - Other ops clear overflow unless stated below.
  - SLT: signed compare; Z=1 if $signed(X) < $signed(Y), else 0.
  - SRL, SLL, SRA: shift amount is the full unsigned Y.
    - Y >= WIDTH gives 0 for SRL/SLL.
    - Y >= WIDTH gives all copies of X[WIDTH-1] for SRA.
  - MUL:
    - Z = low WIDTH bits of the unsigned product.
    - overflow=1 iff the high WIDTH bits are nonzero.
  - Undefined op_code: Z=0, overflow=0, single-cycle.
- Flags:
  - equal is computed from the captured X/Y for every op.
  - zero is computed from the final Z.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: MUL is implemented as above, using a sub-module instance.
- Undefined:
  - `ALU_OP_MUL is treated as an undefined op (Z=0, overflow=0, 1-cycle latency).
  - The MUL state and counter are not synthesised.
  - in_ready never drops for more than the DONE backpressure.

Decomposition:
- Shared header alu_defines.v:
  - Existing `ALU_OP_AND/OR/XOR/NOR/ADD/SUB/SLT/SRL/SLL/SRA are unchanged.
  - Add `ALU_OP_MUL at a code unused by those ten.
  - Add FSM state constants ALU_ST_IDLE/ALU_ST_MUL/ALU_ST_DONE.
- One sub-module: alu_mul_iter.
  - Contents: shift-add multiplier with start/done, multiplicand/multiplier/accumulator registers and a cycle counter.
  - Included only under ALU_MUL_EN.

Test Plan:
- ADD X=7FFFFFFF Y=00000001, out_ready=1 -> next cycle out_valid=1, Z=80000000, overflow=1, zero=0, equal=0.
- SUB X=5 Y=5 -> Z=0, zero=1, equal=1, overflow=0. SLT X=FFFFFFFF Y=1 -> Z=1. SLT X=1 Y=FFFFFFFF -> Z=0.
- Shifts:
  - SRA X=80000000 Y=4 -> F8000000.
  - SRA X=80000000 Y=40 -> FFFFFFFF.
  - SRL X=80000000 Y=40 -> 0.
  - SLL X=1 Y=31 -> 80000000.
- MUL (ALU_MUL_EN defined):
  - X=00010000 Y=00010000 -> Z=0, overflow=1, zero=1; out_valid exactly 33 cycles after accept; in_ready=0 throughout.
  - X=3 Y=7 -> Z=15 (hex), overflow=0.
- Backpressure:
  - After an ADD result, hold out_ready=0 for 5 cycles -> Z/flags constant, in_ready=0.
  - Then out_ready=1 with in_valid=1 -> the next op is accepted that same cycle and its result appears the following cycle.
- rst asserted 10 cycles into a MUL -> next cycle out_valid=0, in_ready=1, Z=0; the aborted result never appears. Undefined op_code (ALU_MUL_EN undefined, `ALU_OP_MUL) -> Z=0, 1-cycle latency.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for alu_pipe: operation encodings and FSM state type.
// Optional feature macro: ALU_MUL_EN (enables the iterative multiply op).
package alu_pipe_pkg;

  // Encodings of the original ten operations are kept; MUL takes the next free code.
  localparam logic [3:0] ALU_OP_AND = 4'd0;
  localparam logic [3:0] ALU_OP_OR  = 4'd1;
  localparam logic [3:0] ALU_OP_XOR = 4'd2;
  localparam logic [3:0] ALU_OP_NOR = 4'd3;
  localparam logic [3:0] ALU_OP_ADD = 4'd4;
  localparam logic [3:0] ALU_OP_SUB = 4'd5;
  localparam logic [3:0] ALU_OP_SLT = 4'd6;
  localparam logic [3:0] ALU_OP_SRL = 4'd7;
  localparam logic [3:0] ALU_OP_SLL = 4'd8;
  localparam logic [3:0] ALU_OP_SRA = 4'd9;
  localparam logic [3:0] ALU_OP_MUL = 4'd10;

  typedef enum logic [1:0] {
    ALU_ST_IDLE = 2'd0,
    ALU_ST_MUL  = 2'd1,
    ALU_ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_pipe_mul_iter.sv
// alu_mul_iter: shift-add unsigned multiplier. A start pulse loads the
// operands; the following WIDTH cycles each add one partial product
// (counter 0..WIDTH-1). done is high during the last iteration cycle and
// product then shows the full 2*WIDTH-bit result that is about to be stored.
// Only instantiated when ALU_MUL_EN is defined.
module alu_mul_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic                 busy;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mplier;
  logic [SHW-1:0]       cnt;
  logic [2*WIDTH-1:0]   acc_next;

  // Accumulator value after the current iteration's partial product.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  assign done    = busy && (cnt == LAST);
  assign product = acc_next;

  // Operand load on start, then one shift-add step per busy cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + SHW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: sequential ALU with valid/ready on both sides and registered
// result flags. One operation in flight at a time.
// Optional feature macro: ALU_MUL_EN (iterative multiply via alu_mul_iter).
//
// Handshake: an input transfer (accept) happens at a rising edge where
// in_valid && in_ready; an output transfer happens at a rising edge where
// out_valid && out_ready. in_ready depends only on state and out_ready,
// never on in_valid, and Z/flags are held stable while out_valid && !out_ready.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [3:0]       op_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             equal,
  output logic             overflow,
  output logic             zero
);

  localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

  alu_state_e       state, state_d;
  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_z;
  logic             mul_ovf;
  logic             mul_eq;

  logic [WIDTH-1:0] alu_z;
  logic             alu_ovf;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             big_shift;

`ifdef ALU_MUL_EN
  localparam int SHW = $clog2(WIDTH);

  logic               mul_start;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] mul_prod;

  assign is_mul = (op_code == ALU_OP_MUL);

  // Capture multiply operands at accept; start the multiplier the cycle after.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_eq    <= 1'b0;
    end else begin
      mul_start <= accept && is_mul;
      if (accept && is_mul) begin
        mul_a  <= X;
        mul_b  <= Y;
        mul_eq <= (X == Y);
      end
    end
  end

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (mul_a),
    .b       (mul_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign mul_z   = mul_prod[WIDTH-1:0];
  assign mul_ovf = |mul_prod[2*WIDTH-1:WIDTH];
`else
  // Without the multiplier, the MUL code decodes as an undefined single-cycle op.
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_z    = '0;
  assign mul_ovf  = 1'b0;
  assign mul_eq   = 1'b0;
`endif

  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ALU_ST_DONE);

  // Single-cycle operation datapath.
  always_comb begin
    alu_z     = '0;
    alu_ovf   = 1'b0;
    sum       = X + Y;
    diff      = X - Y;
    big_shift = (Y >= W_LIM);
    case (op_code)
      ALU_OP_AND: alu_z = X & Y;
      ALU_OP_OR:  alu_z = X | Y;
      ALU_OP_XOR: alu_z = X ^ Y;
      ALU_OP_NOR: alu_z = ~(X | Y);
      ALU_OP_ADD: begin
        alu_z   = sum;
        alu_ovf = (X[WIDTH-1] == Y[WIDTH-1]) && (sum[WIDTH-1] != X[WIDTH-1]);
      end
      ALU_OP_SUB: begin
        alu_z   = diff;
        alu_ovf = (X[WIDTH-1] != Y[WIDTH-1]) && (diff[WIDTH-1] != X[WIDTH-1]);
      end
      ALU_OP_SLT: alu_z = {{(WIDTH-1){1'b0}}, ($signed(X) < $signed(Y))};
      ALU_OP_SRL: alu_z = big_shift ? '0 : (X >> Y);
      ALU_OP_SLL: alu_z = big_shift ? '0 : (X << Y);
      ALU_OP_SRA: alu_z = big_shift ? {WIDTH{X[WIDTH-1]}} : $unsigned($signed(X) >>> Y);
      default:    alu_z = '0;
    endcase
  end

  // Next-state and in_ready decode.
  always_comb begin
    state_d  = state;
    in_ready = 1'b0;
    case (state)
      ALU_ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = is_mul ? ALU_ST_MUL : ALU_ST_DONE;
      end
      ALU_ST_MUL: begin
        if (mul_done) state_d = ALU_ST_DONE;
      end
      ALU_ST_DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) state_d = is_mul ? ALU_ST_MUL : ALU_ST_DONE;
          else          state_d = ALU_ST_IDLE;
        end
      end
      default: state_d = ALU_ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ALU_ST_IDLE;
    else     state <= state_d;
  end

  // Result and flag registers: written on a single-cycle accept or multiply completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      Z        <= '0;
      equal    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept && !is_mul) begin
      Z        <= alu_z;
      equal    <= (X == Y);
      overflow <= alu_ovf;
      zero     <= (alu_z == '0);
    end else if (mul_done) begin
      Z        <= mul_z;
      equal    <= mul_eq;
      overflow <= mul_ovf;
      zero     <= (mul_z == '0);
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe: directed vectors, scoreboard queue checked by a
// monitor at every output transfer, plus latency/backpressure/reset checks.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int W  = 32;
  localparam int EW = W + 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
  logic         equal;
  logic         overflow;
  logic         zero;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

`ifdef ALU_MUL_EN
  localparam int MUL_LAT = W + 1;
`else
  localparam int MUL_LAT = 1;
`endif

  // Clock
  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (x),
    .Y         (y),
    .op_code   (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (z),
    .equal     (equal),
    .overflow  (overflow),
    .zero      (zero)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer pops one expected {Z, equal, overflow, zero}.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got Z=%h with empty queue", z);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({z, equal, overflow, zero} !== e) begin
          errors++;
          $display("FAIL result: got Z=%h eq=%b ov=%b zero=%b expected Z=%h eq=%b ov=%b zero=%b",
                   z, equal, overflow, zero, e[EW-1:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // Driver: present one op, wait for accept, then measure cycles until out_valid.
  task automatic issue(input string name, input logic [3:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ez, input logic eo,
                       input int lat);
    int guard;
    int cyc;
    logic busy_ready;
    exp_q.push_back({ez, (a == b), eo, (ez == '0)});
    op = o; x = a; y = b; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++; errors++;
      $display("FAIL %s_accept: in_ready stayed 0 for %0d cycles", name, guard);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 1;
    busy_ready = 1'b0;
    @(negedge clk);
    while (!out_valid && cyc < 200) begin
      if (in_ready) busy_ready = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, W'(cyc), W'(lat));
    if (lat > 1) check({name, "_in_ready_busy"}, W'(busy_ready), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; op = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_z", z, '0);
    check("rst_flags", W'({equal, overflow, zero}), '0);

    // Back-to-back single-cycle ops with out_ready held high
    issue("add_ovf",  ALU_OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1);
    issue("sub_zero", ALU_OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1);
    issue("slt_neg",  ALU_OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1);
    issue("slt_pos",  ALU_OP_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1);
    issue("sra_4",    ALU_OP_SRA, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1);
    issue("sra_big",  ALU_OP_SRA, 32'h80000000, 32'h00000040, 32'hFFFFFFFF, 1'b0, 1);
    issue("srl_big",  ALU_OP_SRL, 32'h80000000, 32'h00000040, 32'h00000000, 1'b0, 1);
    issue("sll_31",   ALU_OP_SLL, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1);
    issue("sll_32",   ALU_OP_SLL, 32'h00000001, 32'h00000020, 32'h00000000, 1'b0, 1);
    issue("and",      ALU_OP_AND, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 1'b0, 1);
    issue("or",       ALU_OP_OR,  32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF, 1'b0, 1);
    issue("xor",      ALU_OP_XOR, 32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0, 1'b0, 1);
    issue("nor",      ALU_OP_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1);
    issue("sub_ovf",  ALU_OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1);
    issue("add_wrap", ALU_OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1);
    issue("undef",    4'hF,       32'h00000001, 32'h00000002, 32'h00000000, 1'b0, 1);
`ifdef ALU_MUL_EN
    issue("mul_hi",   ALU_OP_MUL, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, MUL_LAT);
    issue("mul_3x7",  ALU_OP_MUL, 32'h00000003, 32'h00000007, 32'h00000015, 1'b0, MUL_LAT);
`else
    issue("mul_undef", ALU_OP_MUL, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0, MUL_LAT);
    issue("mul_undef2", ALU_OP_MUL, 32'h00000003, 32'h00000007, 32'h00000000, 1'b0, MUL_LAT);
`endif

    // Backpressure: hold an ADD result for 5 cycles
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    issue("add_bp", ALU_OP_ADD, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", W'(in_ready), '0);
      check("bp_out_valid", W'(out_valid), W'(1));
      check("bp_z", z, 32'h00000003);
      check("bp_flags", W'({equal, overflow, zero}), '0);
      @(negedge clk);
    end
    // Release and issue a new op in the same cycle
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue("after_bp", ALU_OP_SUB, 32'h00000002, 32'h00000003, 32'hFFFFFFFF, 1'b0, 1);

    // Reset while an operation is in flight (mid-multiply when enabled)
    @(posedge clk);
    #1 out_ready = 1'b0;
    op = ALU_OP_MUL; x = 32'h00000003; y = 32'h00000007; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("abort_out_valid", W'(out_valid), '0);
    check("abort_in_ready", W'(in_ready), W'(1));
    check("abort_z", z, '0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", W'(seen), '0);

    // Block is usable again after the abort
    issue("post_abort", ALU_OP_ADD, 32'h00000002, 32'h00000002, 32'h00000004, 1'b0, 1);
    repeat (3) @(negedge clk);
    check("queue_empty", W'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
